// File: rtl/regfile_arb_if.sv
// regfile_arb_if: bundles the two requester ports and the register-file port
// of regfile_arb. The slave modport is the arbiter; the master modport is the
// surrounding system (requesters plus the register file itself).
interface regfile_arb_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              req_a_;
  logic              req_b_;
  logic              we_a_;
  logic              we_b_;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] din_a;
  logic [DATA_W-1:0] din_b;
  logic              gnt_a_;
  logic              gnt_b_;
  logic [DATA_W-1:0] rdata;
  logic              rvld_a;
  logic              rvld_b;
  logic              rf_we_;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_din;
  logic [DATA_W-1:0] rf_dout;
  logic              busy;

  modport slave (
    input  req_a_, req_b_, we_a_, we_b_, addr_a, addr_b, din_a, din_b, rf_dout,
    output gnt_a_, gnt_b_, rdata, rvld_a, rvld_b, rf_we_, rf_addr, rf_din, busy
  );

  modport master (
    output req_a_, req_b_, we_a_, we_b_, addr_a, addr_b, din_a, din_b, rf_dout,
    input  gnt_a_, gnt_b_, rdata, rvld_a, rvld_b, rf_we_, rf_addr, rf_din, busy
  );
endinterface

// File: rtl/regfile_arb.sv
// regfile_arb: round-robin arbiter letting two requesters share one
// single-port register file. Every output is registered. A requester granted
// in one cycle is not eligible in the next, so a lone continuous requester
// gets every other cycle while two continuous requesters alternate.
// Optional feature macro: REGFILE_ARB_CLEAR_EN. When defined, the first DEPTH
// cycles after each reset release write zero to register-file words
// 0..DEPTH-1 while busy is high; when undefined, arbitration starts at once
// and busy is tied low.
module regfile_arb #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input logic          clk,
  input logic          reset_,
  regfile_arb_if.slave bus
);

`ifdef REGFILE_ARB_CLEAR_EN
  typedef enum logic {ARB, CLEAR} state_t;
  localparam state_t          RESET_STATE = CLEAR;
  localparam logic [ADDR_W:0] CLEAR_END   = (ADDR_W + 1)'(DEPTH);
  logic [ADDR_W:0] clr_cnt;
`else
  typedef enum logic {ARB} state_t;
  localparam state_t RESET_STATE = ARB;
`endif

  state_t state;
  logic   ptr_b;
  logic   elig_a;
  logic   elig_b;
  logic   pick_a;

  // Reject parameter sets where the clear range does not fit the address space.
  if (DEPTH < 1 || DEPTH > (1 << ADDR_W) || DATA_W < 1) begin : g_bad_params
    $error("regfile_arb: DEPTH must lie in 1..2**ADDR_W and DATA_W must be positive");
  end

  // A requester is eligible when asking and not granted in the cycle just ending.
  assign elig_a = !bus.req_a_ && bus.gnt_a_;
  assign elig_b = !bus.req_b_ && bus.gnt_b_;
  assign pick_a = elig_a && (!elig_b || !ptr_b);

`ifndef REGFILE_ARB_CLEAR_EN
  // Without the clear sequence there is never anything to be busy with.
  assign bus.busy = 1'b0;
`endif

  // Single FSM: clear sequencing, grant selection, and read-data capture.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state       <= RESET_STATE;
      ptr_b       <= 1'b0;
      bus.gnt_a_  <= 1'b1;
      bus.gnt_b_  <= 1'b1;
      bus.rf_we_  <= 1'b1;
      bus.rf_addr <= {ADDR_W{1'b0}};
      bus.rf_din  <= {DATA_W{1'b0}};
      bus.rdata   <= {DATA_W{1'b0}};
      bus.rvld_a  <= 1'b0;
      bus.rvld_b  <= 1'b0;
`ifdef REGFILE_ARB_CLEAR_EN
      bus.busy    <= 1'b1;
      clr_cnt     <= '0;
`endif
    end else begin
      bus.gnt_a_ <= 1'b1;
      bus.gnt_b_ <= 1'b1;
      bus.rf_we_ <= 1'b1;
      bus.rvld_a <= !bus.gnt_a_ && bus.rf_we_;
      bus.rvld_b <= !bus.gnt_b_ && bus.rf_we_;
      if ((!bus.gnt_a_ || !bus.gnt_b_) && bus.rf_we_) begin
        bus.rdata <= bus.rf_dout;
      end
      case (state)
`ifdef REGFILE_ARB_CLEAR_EN
        CLEAR: begin
          if (clr_cnt == CLEAR_END) begin
            state    <= ARB;
            bus.busy <= 1'b0;
          end else begin
            bus.rf_we_  <= 1'b0;
            bus.rf_addr <= clr_cnt[ADDR_W-1:0];
            bus.rf_din  <= {DATA_W{1'b0}};
            clr_cnt     <= clr_cnt + 1'b1;
          end
        end
`endif
        ARB: begin
          if (pick_a) begin
            bus.gnt_a_  <= 1'b0;
            bus.rf_we_  <= bus.we_a_;
            bus.rf_addr <= bus.addr_a;
            bus.rf_din  <= bus.din_a;
            ptr_b       <= 1'b1;
          end else if (elig_b) begin
            bus.gnt_b_  <= 1'b0;
            bus.rf_we_  <= bus.we_b_;
            bus.rf_addr <= bus.addr_b;
            bus.rf_din  <= bus.din_b;
            ptr_b       <= 1'b0;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_arb.sv
// tb_regfile_arb: directed bench for regfile_arb with a behavioural register
// file and a read-data scoreboard. Works with or without REGFILE_ARB_CLEAR_EN.
module tb_regfile_arb;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;

  typedef struct packed {
    logic              who;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk;
  logic reset_;
  int   total;
  int   bad;
  int   cyc;
  int   ga_cnt;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [DATA_W-1:0] mem    [DEPTH];
  logic [DATA_W-1:0] shadow [DEPTH];

  logic              a_wr   [4];
  logic [ADDR_W-1:0] a_addr [4];
  logic [DATA_W-1:0] a_data [4];
  logic              b_wr   [4];
  logic [ADDR_W-1:0] b_addr [4];
  logic [DATA_W-1:0] b_data [4];
  int                g_who  [8];
  int                g_cyc  [8];
  int                n_grants;
  int                ia;
  int                ib;

  regfile_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used for grant timing.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register file: write at the clock edge, asynchronous read.
  always @(posedge clk) begin
    if (bus.rf_we_ === 1'b0) mem[bus.rf_addr] <= bus.rf_din;
  end
  assign bus.rf_dout = mem[bus.rf_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Scoreboard monitor: read data, grant exclusivity, grant counting.
  always @(negedge clk) begin
    if (reset_ === 1'b1) begin
      if (bus.gnt_a_ === 1'b0) ga_cnt++;
      check("one_grant", 64'(bus.gnt_a_ === 1'b0 && bus.gnt_b_ === 1'b0), 64'd0);
      if (bus.rvld_a === 1'b1 || bus.rvld_b === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("rvld_unexpected", {62'd0, bus.rvld_a, bus.rvld_b}, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rvld_owner", {62'd0, bus.rvld_a, bus.rvld_b}, mon_e.who ? 64'd1 : 64'd2);
          check("rdata", 64'(bus.rdata), 64'(mon_e.data));
        end
      end
    end
  end

  task automatic drive_a(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req_a_ = 1'b0;
    bus.we_a_  = !wr;
    bus.addr_a = a;
    bus.din_a  = d;
  endtask

  task automatic drive_b(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req_b_ = 1'b0;
    bus.we_b_  = !wr;
    bus.addr_b = a;
    bus.din_b  = d;
  endtask

  task automatic push_exp(input logic who, input logic [DATA_W-1:0] d);
    exp_t e;
    e.who  = who;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_reset(input string tag, input logic want_busy);
    check({tag, "_gnt"},   {62'd0, bus.gnt_a_, bus.gnt_b_}, 64'd3);
    check({tag, "_rf_we"}, 64'(bus.rf_we_),   64'd1);
    check({tag, "_addr"},  64'(bus.rf_addr),  64'd0);
    check({tag, "_din"},   64'(bus.rf_din),   64'd0);
    check({tag, "_rdata"}, 64'(bus.rdata),    64'd0);
    check({tag, "_rvld"},  {62'd0, bus.rvld_a, bus.rvld_b}, 64'd0);
    check({tag, "_busy"},  64'(bus.busy),     64'(want_busy));
  endtask

  task automatic check_clear(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check({tag, "_busy"},  64'(bus.busy),    64'd1);
      check({tag, "_rf_we"}, 64'(bus.rf_we_),  64'd0);
      check({tag, "_addr"},  64'(bus.rf_addr), 64'(i));
      check({tag, "_din"},   64'(bus.rf_din),  64'd0);
      check({tag, "_gnt"},   {62'd0, bus.gnt_a_, bus.gnt_b_}, 64'd3);
    end
    @(negedge clk);
    check({tag, "_end_busy"},  64'(bus.busy),   64'd0);
    check({tag, "_end_rf_we"}, 64'(bus.rf_we_), 64'd1);
    check({tag, "_end_gnt"},   {62'd0, bus.gnt_a_, bus.gnt_b_}, 64'd3);
  endtask

  // Single access by one requester; returns how many cycles the grant took.
  task automatic access(input logic who, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, output int waits);
    logic got;
    got   = 1'b0;
    waits = 0;
    if (!wr) push_exp(who, shadow[a]);
    if (who) drive_b(wr, a, d); else drive_a(wr, a, d);
    while (!got && waits < 50) begin
      @(negedge clk);
      waits++;
      got = who ? (bus.gnt_b_ === 1'b0) : (bus.gnt_a_ === 1'b0);
    end
    check("access_granted", 64'(got), 64'd1);
    if (got) begin
      check("grant_rf_we",   64'(bus.rf_we_),  64'(!wr));
      check("grant_rf_addr", 64'(bus.rf_addr), 64'(a));
      if (wr) begin
        check("grant_rf_din", 64'(bus.rf_din), 64'(d));
        shadow[a] = d;
      end
    end
    if (who) bus.req_b_ = 1'b1; else bus.req_a_ = 1'b1;
  endtask

  task automatic start_lists(input int na, input int nb);
    ia = 0;
    ib = 0;
    n_grants = 0;
    if (na > 0) drive_a(a_wr[0], a_addr[0], a_data[0]);
    if (nb > 0) drive_b(b_wr[0], b_addr[0], b_data[0]);
  endtask

  // Both requesters work through their lists, re-requesting right after each grant.
  task automatic collect_lists(input int na, input int nb);
    for (int c = 0; c < 80 && (ia < na || ib < nb); c++) begin
      @(negedge clk);
      if (bus.gnt_a_ === 1'b0 && ia < na) begin
        if (a_wr[ia]) shadow[a_addr[ia]] = a_data[ia];
        g_who[n_grants] = 0;
        g_cyc[n_grants] = cyc;
        n_grants++;
        ia++;
        if (ia < na) drive_a(a_wr[ia], a_addr[ia], a_data[ia]); else bus.req_a_ = 1'b1;
      end
      if (bus.gnt_b_ === 1'b0 && ib < nb) begin
        if (b_wr[ib]) shadow[b_addr[ib]] = b_data[ib];
        g_who[n_grants] = 1;
        g_cyc[n_grants] = cyc;
        n_grants++;
        ib++;
        if (ib < nb) drive_b(b_wr[ib], b_addr[ib], b_data[ib]); else bus.req_b_ = 1'b1;
      end
    end
    check("lists_done", 64'(ia == na && ib == nb), 64'd1);
    bus.req_a_ = 1'b1;
    bus.req_b_ = 1'b1;
  endtask

  initial begin
    int w;
    int rel_cyc;
    int ga_before;
    logic exp_busy;
    total  = 0;
    bad    = 0;
    cyc    = 0;
    ga_cnt = 0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    bus.req_a_ = 1'b1;
    bus.req_b_ = 1'b1;
    bus.we_a_  = 1'b1;
    bus.we_b_  = 1'b1;
    bus.addr_a = '0;
    bus.addr_b = '0;
    bus.din_a  = '0;
    bus.din_b  = '0;
`ifdef REGFILE_ARB_CLEAR_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
`endif

    reset_ = 1'b1;
    #2 reset_ = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset("rst", exp_busy);
    reset_  = 1'b1;
    rel_cyc = cyc;

`ifdef REGFILE_ARB_CLEAR_EN
    check_clear("clr");
`else
    a_wr[0] = 1'b1; a_addr[0] = 5'd7; a_data[0] = 32'h0000_0077;
    b_wr[0] = 1'b1; b_addr[0] = 5'd8; b_data[0] = 32'h0000_0088;
    start_lists(1, 1);
    collect_lists(1, 1);
    check("first_grant_lat", 64'(g_cyc[0] - rel_cyc), 64'd1);
    check("first_order",     64'(g_who[0] * 2 + g_who[1]), 64'd1);
    check("no_clear_busy",   64'(bus.busy), 64'd0);
`endif

    // Single write then read by A.
    @(negedge clk);
    ga_before = ga_cnt;
    access(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, w);
    check("wr5_wait", 64'(w), 64'd1);
    access(1'b0, 1'b0, 5'd5, '0, w);
    check("rd5_every_other", 64'(w), 64'd2);
    @(negedge clk);
    check("rd5_rvld_a", 64'(bus.rvld_a), 64'd1);
    check("rd5_rdata",  64'(bus.rdata),  64'hDEAD_BEEF);
    @(negedge clk);
    check("rd5_rvld_pulse", 64'(bus.rvld_a), 64'd0);
    check("gnt_a_pulses",   64'(ga_cnt - ga_before), 64'd2);

    // Read-after-write: B writes 3 and A reads 3 on the very next cycle.
    a_wr[0] = 1'b0; a_addr[0] = 5'd3; a_data[0] = '0;
    b_wr[0] = 1'b1; b_addr[0] = 5'd3; b_data[0] = 32'h0000_0012;
    push_exp(1'b0, 32'h0000_0012);
    start_lists(1, 1);
    collect_lists(1, 1);
    check("raw_order", 64'(g_who[0] * 2 + g_who[1]), 64'd2);
    check("raw_gap",   64'(g_cyc[1] - g_cyc[0]),     64'd1);

    // Lone B read leaves the pointer at A.
    @(negedge clk);
    access(1'b1, 1'b0, 5'd3, '0, w);
    check("b_rd3_wait", 64'(w), 64'd1);

    // Continuous contention with pointer at A: A,B,A,B,...
    @(negedge clk);
    a_wr[0] = 1'b1; a_addr[0] = 5'd10; a_data[0] = 32'h1111_1111;
    a_wr[1] = 1'b0; a_addr[1] = 5'd10; a_data[1] = '0;
    a_wr[2] = 1'b1; a_addr[2] = 5'd12; a_data[2] = 32'h3333_3333;
    a_wr[3] = 1'b0; a_addr[3] = 5'd12; a_data[3] = '0;
    b_wr[0] = 1'b1; b_addr[0] = 5'd11; b_data[0] = 32'h2222_2222;
    b_wr[1] = 1'b0; b_addr[1] = 5'd11; b_data[1] = '0;
    b_wr[2] = 1'b1; b_addr[2] = 5'd13; b_data[2] = 32'h4444_4444;
    b_wr[3] = 1'b0; b_addr[3] = 5'd13; b_data[3] = '0;
    push_exp(1'b0, 32'h1111_1111);
    push_exp(1'b1, 32'h2222_2222);
    push_exp(1'b0, 32'h3333_3333);
    push_exp(1'b1, 32'h4444_4444);
    start_lists(4, 4);
    collect_lists(4, 4);
    check("cont_count", 64'(n_grants), 64'd8);
    for (int i = 0; i < n_grants; i++) begin
      check("cont_who", 64'(g_who[i]), 64'(i % 2));
      if (i > 0) check("cont_gap", 64'(g_cyc[i] - g_cyc[i-1]), 64'd1);
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);

`ifdef REGFILE_ARB_CLEAR_EN
    // Reset in the middle of the clear sequence, then requests during clear.
    reset_ = 1'b0;
    @(negedge clk);
    reset_ = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (bus.rf_addr !== 5'd10 && w < 40);
    check("abort_reach10", 64'(w), 64'd11);
    reset_ = 1'b0;
    #1;
    check_reset("abort", 1'b1);
    @(negedge clk);
    reset_  = 1'b1;
    rel_cyc = cyc;
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    a_wr[0] = 1'b0; a_addr[0] = 5'd10; a_data[0] = '0;
    b_wr[0] = 1'b0; b_addr[0] = 5'd11; b_data[0] = '0;
    push_exp(1'b0, '0);
    push_exp(1'b1, '0);
    start_lists(1, 1);
    check_clear("reclr");
    collect_lists(1, 1);
    check("reclr_grant_lat", 64'(g_cyc[0] - rel_cyc), 64'(DEPTH + 2));
    check("reclr_order",     64'(g_who[0] * 2 + g_who[1]), 64'd1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
`endif

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
